turn_scheduler: RTL and testbench

TURN_SCHEDULER -- requirements
Module: turn_scheduler

---
 rtl/turn_scheduler.sv | 127 ++++++++++++
 tb/tb_turn_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/turn_scheduler.sv
// Two-player artillery turn sequencer: Enter starts a game, players alternate aiming and firing.
// One edge per video frame; every output is a register or a decode of the state register.
module turn_scheduler #(
  parameter int TURN_FRAMES = 600,
  parameter int FLIGHT_MAX  = 240,
  parameter int LIVES       = 3
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [3:0] power_p1,
  input  logic [3:0] angle_p1,
  input  logic [3:0] power_p2,
  input  logic [3:0] angle_p2,
  input  logic       proj_done,
  input  logic       hit_p1,
  input  logic       hit_p2,
  output logic       p1_in_turn,
  output logic       p2_in_turn,
  output logic       fire,
  output logic [3:0] fire_power,
  output logic [3:0] fire_angle,
  output logic [1:0] lives_p1,
  output logic [1:0] lives_p2,
  output logic [9:0] turn_timer,
  output logic [1:0] winner,
  output logic       game_over
);
  localparam int FW = $clog2(FLIGHT_MAX + 1);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] KEY_ENTER = 8'd40;
  localparam logic [7:0] KEY_SPACE = 8'd44;

  typedef enum logic [2:0] {IDLE, P1_AIM, P2_AIM, FLIGHT, SWITCH, GAME_OVER} state_t;

  state_t          state;
  logic [7:0]      key_prev;
  logic [FW-1:0]   flight_cnt;
  logic            shooter_p2;
  logic            enter_ev;
  logic            fire_ev;

  assign enter_ev = (keycode == KEY_ENTER) && (key_prev != KEY_ENTER);
  assign fire_ev  = (keycode == KEY_SPACE) && (key_prev != KEY_SPACE);

  function automatic logic [1:0] dec_sat(input logic [1:0] l);
    return (l == 2'd0) ? 2'd0 : l - 2'd1;
  endfunction

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state      <= IDLE;
      key_prev   <= 8'd0;
      fire       <= 1'b0;
      fire_power <= 4'd0;
      fire_angle <= 4'd0;
      lives_p1   <= LIVES_INIT;
      lives_p2   <= LIVES_INIT;
      turn_timer <= 10'd0;
      winner     <= 2'b00;
      flight_cnt <= '0;
      shooter_p2 <= 1'b0;
    end else begin
      key_prev <= keycode;
      fire     <= 1'b0;
      case (state)
        IDLE: if (enter_ev) begin
          state      <= P1_AIM;
          lives_p1   <= LIVES_INIT;
          lives_p2   <= LIVES_INIT;
          turn_timer <= 10'd0;
          winner     <= 2'b00;
        end
        P1_AIM, P2_AIM: begin
          turn_timer <= turn_timer + 10'd1;
          shooter_p2 <= (state == P2_AIM);
          // A shot on the last aim frame still counts; only an idle final frame forfeits.
          if (fire_ev) begin
            state      <= FLIGHT;
            fire       <= 1'b1;
            fire_power <= (state == P1_AIM) ? power_p1 : power_p2;
            fire_angle <= (state == P1_AIM) ? angle_p1 : angle_p2;
            flight_cnt <= '0;
          end else if (turn_timer == 10'(TURN_FRAMES - 1)) begin
            state <= SWITCH;
          end
        end
        FLIGHT: begin
          if (proj_done) begin
            state <= SWITCH;
            if (hit_p1) lives_p1 <= dec_sat(lives_p1);
            if (hit_p2) lives_p2 <= dec_sat(lives_p2);
          end else if (flight_cnt == FW'(FLIGHT_MAX - 1)) begin
            state <= SWITCH;
          end else begin
            flight_cnt <= flight_cnt + 1'b1;
          end
        end
        SWITCH: begin
          if (lives_p1 == 2'd0 && lives_p2 == 2'd0) begin
            winner <= 2'b11;
            state  <= GAME_OVER;
          end else if (lives_p1 == 2'd0) begin
            winner <= 2'b10;
            state  <= GAME_OVER;
          end else if (lives_p2 == 2'd0) begin
            winner <= 2'b01;
            state  <= GAME_OVER;
          end else begin
            state      <= shooter_p2 ? P1_AIM : P2_AIM;
            turn_timer <= 10'd0;
          end
        end
        GAME_OVER: if (enter_ev) begin
          state  <= IDLE;
          winner <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign p1_in_turn = (state == P1_AIM);
  assign p2_in_turn = (state == P2_AIM);
  assign game_over  = (state == GAME_OVER);

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler: a game-level model checked every cycle plus literal spot checks.
module tb_turn_scheduler;
  localparam int TF = 8;
  localparam int FM = 16;
  localparam int LV = 3;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] keycode = 8'd0;
  logic [3:0] power_p1 = 4'd0, angle_p1 = 4'd0, power_p2 = 4'd0, angle_p2 = 4'd0;
  logic       proj_done = 1'b0, hit_p1 = 1'b0, hit_p2 = 1'b0;
  logic       p1_in_turn, p2_in_turn, fire, game_over;
  logic [3:0] fire_power, fire_angle;
  logic [1:0] lives_p1, lives_p2, winner;
  logic [9:0] turn_timer;

  turn_scheduler #(.TURN_FRAMES(TF), .FLIGHT_MAX(FM), .LIVES(LV)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .power_p1(power_p1), .angle_p1(angle_p1), .power_p2(power_p2), .angle_p2(angle_p2),
    .proj_done(proj_done), .hit_p1(hit_p1), .hit_p2(hit_p2),
    .p1_in_turn(p1_in_turn), .p2_in_turn(p2_in_turn), .fire(fire),
    .fire_power(fire_power), .fire_angle(fire_angle),
    .lives_p1(lives_p1), .lives_p2(lives_p2), .turn_timer(turn_timer),
    .winner(winner), .game_over(game_over)
  );

  always #5 frame_clk = ~frame_clk;

  int errors = 0;
  int checks = 0;
  int fire_cnt = 0;
  bit run_checks = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: phase 0 idle, 1 aiming, 2 shell in flight, 3 hand-over, 4 finished.
  int m_phase = 0, m_player = 1, m_elapsed = 0, m_age = 0;
  int m_l1 = LV, m_l2 = LV, m_win = 0, m_fire = 0, m_pow = 0, m_ang = 0, m_prev = 0;

  always @(posedge frame_clk) begin
    bit ent, shot;
    if (Reset) begin
      m_phase = 0; m_elapsed = 0; m_age = 0; m_l1 = LV; m_l2 = LV;
      m_win = 0; m_fire = 0; m_pow = 0; m_ang = 0; m_prev = 0;
    end else begin
      ent    = (keycode == 40) && (m_prev != 40);
      shot   = (keycode == 44) && (m_prev != 44);
      m_prev = keycode;
      m_fire = 0;
      if (m_phase == 0) begin
        if (ent) begin m_phase = 1; m_player = 1; m_elapsed = 0; m_l1 = LV; m_l2 = LV; m_win = 0; end
      end else if (m_phase == 1) begin
        if (shot) begin
          m_phase = 2; m_fire = 1; m_age = 0;
          m_pow = (m_player == 1) ? power_p1 : power_p2;
          m_ang = (m_player == 1) ? angle_p1 : angle_p2;
        end else if (m_elapsed == TF - 1) m_phase = 3;
        m_elapsed++;
      end else if (m_phase == 2) begin
        if (proj_done) begin
          if (hit_p1 && m_l1 > 0) m_l1--;
          if (hit_p2 && m_l2 > 0) m_l2--;
          m_phase = 3;
        end else if (m_age == FM - 1) m_phase = 3;
        else m_age++;
      end else if (m_phase == 3) begin
        if (m_l1 == 0 || m_l2 == 0) begin
          m_phase = 4;
          m_win = (m_l1 == 0 ? 2 : 0) + (m_l2 == 0 ? 1 : 0);
        end else begin
          m_phase = 1; m_player = 3 - m_player; m_elapsed = 0;
        end
      end else begin
        if (ent) begin m_phase = 0; m_win = 0; end
      end
    end
  end

  always @(negedge frame_clk) begin
    if (fire === 1'b1) fire_cnt++;
    if (run_checks) begin
      chk("p1_in_turn", p1_in_turn, (m_phase == 1 && m_player == 1));
      chk("p2_in_turn", p2_in_turn, (m_phase == 1 && m_player == 2));
      chk("fire", fire, m_fire);
      chk("fire_power", fire_power, m_pow);
      chk("fire_angle", fire_angle, m_ang);
      chk("lives_p1", lives_p1, m_l1);
      chk("lives_p2", lives_p2, m_l2);
      chk("turn_timer", turn_timer, m_elapsed);
      chk("winner", winner, m_win);
      chk("game_over", game_over, (m_phase == 4));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge frame_clk);
    #2;
  endtask

  initial begin
    int f0;
    cyc(2);
    Reset = 1'b0;
    run_checks = 1'b1;
    cyc(1);
    chk("rst_lives_p1", lives_p1, 3);
    chk("rst_lives_p2", lives_p2, 3);
    chk("rst_winner", winner, 0);
    chk("rst_fire_power", fire_power, 0);
    chk("rst_p1_in_turn", p1_in_turn, 0);

    keycode = 8'd40; cyc(1); keycode = 8'd0;
    chk("start_p1_in_turn", p1_in_turn, 1);
    chk("start_timer0", turn_timer, 0);
    cyc(2);
    chk("start_timer2", turn_timer, 2);

    power_p1 = 4'd5; angle_p1 = 4'd3;
    f0 = fire_cnt;
    keycode = 8'd44; cyc(1);
    chk("shot_fire", fire, 1);
    chk("shot_power", fire_power, 5);
    chk("shot_angle", fire_angle, 3);
    chk("shot_p1_off", p1_in_turn, 0);
    cyc(9); keycode = 8'd0;
    chk("held_space_pulses", fire_cnt - f0, 1);

    proj_done = 1'b1; hit_p2 = 1'b1; cyc(1); proj_done = 1'b0; hit_p2 = 1'b0;
    chk("hit_lives_p2", lives_p2, 2);
    chk("switch_p2_off", p2_in_turn, 0);
    cyc(1);
    chk("p2_turn", p2_in_turn, 1);
    chk("p2_timer0", turn_timer, 0);

    f0 = fire_cnt;
    cyc(TF);
    chk("forfeit_in_switch", p2_in_turn, 0);
    cyc(1);
    chk("forfeit_no_fire", fire_cnt - f0, 0);
    chk("forfeit_to_p1", p1_in_turn, 1);

    cyc(TF - 1);
    chk("last_frame_timer", turn_timer, TF - 1);
    keycode = 8'd44; cyc(1); keycode = 8'd0;
    chk("last_frame_fire", fire, 1);
    cyc(FM);
    chk("flight_timeout_lives_p1", lives_p1, 3);
    chk("flight_timeout_lives_p2", lives_p2, 2);
    cyc(1);
    chk("timeout_to_p2", p2_in_turn, 1);

    power_p2 = 4'd9; angle_p2 = 4'd12;
    keycode = 8'd44; cyc(1); keycode = 8'd0;
    chk("p2_power", fire_power, 9);
    chk("p2_angle", fire_angle, 12);
    proj_done = 1'b1; hit_p1 = 1'b1; cyc(1); proj_done = 1'b0; hit_p1 = 1'b0;
    chk("p1_hit_lives_p1", lives_p1, 2);
    cyc(1);
    chk("back_to_p1", p1_in_turn, 1);

    keycode = 8'd44; cyc(1); keycode = 8'd0;
    chk("relatch_power", fire_power, 5);
    proj_done = 1'b1; hit_p1 = 1'b1; hit_p2 = 1'b1; cyc(1);
    proj_done = 1'b0; hit_p1 = 1'b0; hit_p2 = 1'b0;
    chk("both_lives_p1_1", lives_p1, 1);
    chk("both_lives_p2_1", lives_p2, 1);
    cyc(1);

    keycode = 8'd44; cyc(1); keycode = 8'd0;
    proj_done = 1'b1; hit_p1 = 1'b1; hit_p2 = 1'b1; cyc(1);
    proj_done = 1'b0; hit_p1 = 1'b0; hit_p2 = 1'b0;
    chk("final_lives_p1", lives_p1, 0);
    chk("final_lives_p2", lives_p2, 0);
    cyc(1);
    chk("draw_winner", winner, 3);
    chk("draw_game_over", game_over, 1);
    cyc(3);
    chk("draw_holds", winner, 3);
    keycode = 8'd40; cyc(3);
    chk("over_to_idle_winner", winner, 0);
    chk("over_to_idle_go", game_over, 0);
    chk("held_enter_one_event", p1_in_turn, 0);

    keycode = 8'd50; cyc(2);
    keycode = 8'd44; cyc(2);
    chk("idle_ignores_space", fire, 0);
    chk("idle_ignores_keys", p1_in_turn, 0);
    keycode = 8'd0; cyc(1);
    keycode = 8'd40; cyc(1); keycode = 8'd0;
    chk("restart_lives", lives_p1, 3);
    keycode = 8'd44; cyc(1); keycode = 8'd0;
    cyc(2);
    Reset = 1'b1; proj_done = 1'b1; hit_p1 = 1'b1; cyc(1);
    chk("rst_flight_lives_p1", lives_p1, 3);
    chk("rst_flight_fire", fire, 0);
    chk("rst_flight_power", fire_power, 0);
    chk("rst_flight_in_turn", p1_in_turn, 0);
    Reset = 1'b0; proj_done = 1'b0; hit_p1 = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
